// File: rtl/regfile_serial_mp.sv
// rtl/regfile_serial_mp.sv - digit-serial register file with two read ports and one write port
//
// Purpose:
//   A REG_COUNT x REG_WIDTH register file that moves one word per transfer,
//   DIGIT bits per cycle, least significant digit first. A transfer reads two
//   source registers and optionally writes one destination register.
//
// Ports:
//   clk         in   1      clock, all state on rising edge
//   rst         in   1      asynchronous active-high reset
//   start       in   1      request a transfer (sampled in IDLE only)
//   stall       in   1      freeze the transfer for this cycle
//   rs1_addr    in   AW     read select 1, latched on accepted start
//   rs2_addr    in   AW     read select 2, latched on accepted start
//   rd_addr     in   AW     write select, latched on accepted start
//   wr_en       in   1      write enable for the transfer, latched on accepted start
//   wr_digit    in   DIGIT  write data digit for the current digit index
//   rs1_digit   out  DIGIT  read data digit of source 1
//   rs2_digit   out  DIGIT  read data digit of source 2
//   digit_idx   out  IW     current digit index, 0 = least significant
//   digit_valid out  1      a digit moves this cycle
//   last_digit  out  1      the moving digit is the most significant one
//   busy        out  1      transfer in progress (SHIFT or DONE)
//   done        out  1      one-cycle completion pulse

module regfile_serial_mp #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 8,
  parameter int DIGIT     = 1,
  parameter int ZERO_REG  = 1,
  localparam int AW = $clog2(REG_COUNT),
  localparam int N  = REG_WIDTH / DIGIT,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic          wr_en,
  input  logic [DIGIT-1:0] wr_digit,
  output logic [DIGIT-1:0] rs1_digit,
  output logic [DIGIT-1:0] rs2_digit,
  output logic [IW-1:0] digit_idx,
  output logic          digit_valid,
  output logic          last_digit,
  output logic          busy,
  output logic          done
);

  // Width of a bit offset inside one register.
  localparam int BW = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   rs1_q;
  logic [AW-1:0]   rs2_q;
  logic [AW-1:0]   rd_q;
  logic            wen_q;
  logic [REG_WIDTH-1:0] regs [REG_COUNT];

  logic [BW-1:0]   bit_off;
  logic            in_shift;
  logic            wr_fire;
  logic            rs1_zero;
  logic            rs2_zero;
  logic [REG_WIDTH-1:0] rs1_word;
  logic [REG_WIDTH-1:0] rs2_word;

  assign bit_off     = BW'(int'(digit_idx) * DIGIT);
  assign in_shift    = (state == SHIFT);
  assign digit_valid = in_shift && !stall;
  assign last_digit  = digit_valid && (digit_idx == LAST_IDX);

  // Register 0 is hardwired to zero only when ZERO_REG is set.
  assign rs1_zero = (ZERO_REG != 0) && (rs1_q == '0);
  assign rs2_zero = (ZERO_REG != 0) && (rs2_q == '0);
  assign wr_fire  = digit_valid && wen_q && !((ZERO_REG != 0) && (rd_q == '0));

  assign rs1_word = regs[rs1_q];
  assign rs2_word = regs[rs2_q];

  // Reads show the stored (pre-write) digit; a same-cycle write lands on the edge.
  always_comb begin
    rs1_digit = '0;
    rs2_digit = '0;
    if (in_shift) begin
      if (!rs1_zero) rs1_digit = rs1_word[bit_off +: DIGIT];
      if (!rs2_zero) rs2_digit = rs2_word[bit_off +: DIGIT];
    end
  end

  // Transfer sequencer with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      digit_idx <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            digit_idx <= '0;
            rs1_q     <= rs1_addr;
            rs2_q     <= rs2_addr;
            rd_q      <= rd_addr;
            wen_q     <= wr_en;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (!stall) begin
            if (digit_idx == LAST_IDX) begin
              state     <= DONE;
              digit_idx <= '0;
              done      <= 1'b1;
            end else begin
              digit_idx <= digit_idx + IW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: one digit of the latched destination per moving cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[rd_q][bit_off +: DIGIT] <= wr_digit;
    end
  end

endmodule
